// File: rtl/nibble_serial_adder_ctrl.sv
// ============================================================================
// Module  : nibble_serial_adder_ctrl (with full_adder4)
// Brief   : Adds or subtracts WIDTH-bit operands one nibble per cycle,
//           least significant nibble first, on a single shared 4-bit adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_adder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o,
  output logic       c3_o
);

  logic [4:0] w_c;

  assign w_c[0] = c_i;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
    assign w_c[i+1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o  = w_c[4];
  // Carry into the top bit; with c_o it yields signed overflow of the nibble.
  assign c3_o = w_c[3];

endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cr_q, cr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [3:0]       w_nib_s;
  logic             w_nib_co;
  logic             w_nib_c3;

  assign w_nib_a = a_q[4*idx_q +: 4];
  assign w_nib_b = b_q[4*idx_q +: 4];

  full_adder4 u_fa4 (
    .a_i  (w_nib_a),
    .b_i  (w_nib_b),
    .c_i  (cr_q),
    .s_o  (w_nib_s),
    .c_o  (w_nib_co),
    .c3_o (w_nib_c3)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cr_q    <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cr_q    <= cr_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cr_d    = cr_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ov_d    = ov_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so the inversion happens at capture.
          a_d     = a;
          b_d     = sub ? ~b : b;
          cr_d    = sub ? 1'b1 : c_in;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[4*idx_q +: 4] = w_nib_s;
        cr_d                = w_nib_co;
        if (idx_q == LAST_IDX) begin
          co_d    = w_nib_co;
          ov_d    = w_nib_c3 ^ w_nib_co;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_ADD);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign carry    = co_q;
  assign overflow = ov_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ============================================================================
// Module  : tb_nibble_serial_adder_ctrl
// Brief   : Self-checking bench: vector table, scoreboard queue, corner cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic             sub;
  logic             c_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  typedef struct {
    logic             sub;
    logic             c_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_carry;
    logic             exp_ovf;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .c_in     (c_in),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Independent model: plain WIDTH+1 bit arithmetic, sign rule for overflow.
  function automatic res_t model(input logic s, input logic ci,
                                 input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    res_t r;
    logic [WIDTH:0] full;
    if (s) full = {1'b0, av} - {1'b0, bv} + (1 << WIDTH);
    else   full = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, ci};
    r.s = full[WIDTH-1:0];
    r.c = full[WIDTH];
    if (s) r.o = (av[WIDTH-1] != bv[WIDTH-1]) && (r.s[WIDTH-1] != av[WIDTH-1]);
    else   r.o = (av[WIDTH-1] == bv[WIDTH-1]) && (r.s[WIDTH-1] != av[WIDTH-1]);
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sb_sum", 32'(sum), 32'(e.s));
        chk("sb_carry", 32'(carry), 32'(e.c));
        chk("sb_ovf", 32'(overflow), 32'(e.o));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ready), 32'd1);
  endtask

  // One operation with cycle-exact handshake checks; poke=1 fires a stray
  // start in the second busy cycle that must be ignored.
  task automatic do_op(input logic s, input logic ci,
                       input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input res_t e, input bit poke);
    wait_ready();
    sub = s; c_in = ci; a = av; b = bv; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    c_in = 1'($urandom); sub = 1'($urandom);
    for (int i = 1; i <= NIBBLES; i++) begin
      chk("busy_phase", {29'd0, busy, ready, done}, 32'b100);
      if (poke && i == 2) begin
        start = 1'b1; a = 16'h1111; b = 16'h1111; sub = 1'b0; c_in = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("done_phase", {29'd0, busy, ready, done}, 32'b001);
    @(negedge clk);
    chk("idle_after", {29'd0, busy, ready, done}, 32'b010);
    chk("sum_hold", 32'(sum), 32'(e.s));
    chk("carry_hold", 32'(carry), 32'(e.c));
  endtask

  function automatic res_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
    res_t r;
    r.s = s; r.c = c; r.o = o;
    return r;
  endfunction

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {29'd0, busy, ready, done}, 32'b010);
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].sub, vecs[i].c_in, vecs[i].a, vecs[i].b,
            mk(vecs[i].exp_sum, vecs[i].exp_carry, vecs[i].exp_ovf), 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      logic             rs, rc;
      logic [WIDTH-1:0] ra, rb;
      rs = 1'($urandom); rc = 1'($urandom);
      ra = WIDTH'($urandom); rb = WIDTH'($urandom);
      do_op(rs, rc, ra, rb, model(rs, rc, ra, rb), 1'b0);
    end

    // Stray start during busy must not disturb 0x0F0F + 0x00F1.
    do_op(1'b0, 1'b0, 16'h0F0F, 16'h00F1, mk(16'h1000, 1'b0, 1'b0), 1'b1);
    repeat (8) @(negedge clk);

    // Start held high: done every NIBBLES+2 cycles, three operations.
    wait_ready();
    sub = 1'b0; c_in = 1'b0; a = 16'h0101; b = 16'h0202; start = 1'b1;
    repeat (3) exp_q.push_back(mk(16'h0303, 1'b0, 1'b0));
    for (int c = 1; c <= 3 * (NIBBLES + 2) - 1; c++) begin
      @(negedge clk);
      chk("b2b_done", 32'(done), 32'((c % (NIBBLES + 2)) == NIBBLES + 1));
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the second ADD cycle aborts without a done pulse.
    wait_ready();
    sub = 1'b0; c_in = 1'b0; a = 16'hABCD; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_flags", {29'd0, busy, ready, done}, 32'b010);
    chk("abort_sum", 32'(sum), 32'h0);
    chk("abort_carry", 32'(carry), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    repeat (8) @(negedge clk);
    do_op(1'b0, 1'b0, 16'h0001, 16'h0001, mk(16'h0002, 1'b0, 1'b0), 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that runs one shared 4-bit ripple-carry adder (full_adder4) over WIDTH/4 cycles to add or subtract WIDTH-bit operands, least significant nibble first.
- Sits between the switch/operand capture logic and the FND display driver.
- Uses a start/done handshake, latches its operands, and holds its result until the next operation.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived; number of adder passes (ADD cycles) per operation.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- sub  input  1  0 = a+b+c_in; 1 = a-b (b inverted, c_in forced to 1). Sampled with start.
- c_in  input  1  carry-in for add mode. Sampled with start. Ignored when sub=1.
- a  input  WIDTH  operand A. Sampled with start.
- b  input  WIDTH  operand B. Sampled with start.
- ready  output  1  idle; a start is accepted this cycle.
- busy  output  1  nibble passes in progress.
- done  output  1  one-cycle pulse: result is valid.
- sum  output  WIDTH  result.
- carry  output  1  carry out of the MSB nibble. In sub mode, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Everything is registered on clk.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, carry=0, overflow=0, nibble index=0, carry register=0, operand registers=0.
- Reset has priority over all other inputs. Reset asserted mid-operation aborts it: no done pulse, and all outputs return to their reset values on the next edge.
- State IDLE (ready=1):
  - start=1 at an edge latches a into A_reg.
  - The same edge latches b into B_reg, or ~b when sub=1.
  - The same edge sets the carry register to sub ? 1 : c_in, sets idx=0, and moves to ADD.
  - sum/carry/overflow keep their previous values until overwritten.
- State ADD (busy=1, ready=0):
  - The adder inputs are A_reg[4*idx+:4], B_reg[4*idx+:4] and the carry register.
  - At each edge, the adder sum is written to sum[4*idx+:4] and its carry-out to the carry register.
  - Also at each edge, the carry into bit 3 of the current nibble is captured. This is only needed when idx=NIBBLES-1, for overflow.
  - idx increments each cycle. When idx=NIBBLES-1, the machine moves to DONE instead, and the final carry and overflow are registered.
- State DONE (done=1, busy=0, ready=0): lasts exactly one cycle, then returns to IDLE.
- Latency: start sampled at edge k gives busy=1 in cycles k+1..k+NIBBLES and done=1 in cycle k+NIBBLES+1. For WIDTH=16, done appears 5 cycles after the start edge.
- start while busy or done is ignored; no queuing.
- Operand inputs may change freely after the start edge; the operation uses only the latched values.
- Back-to-back operations: start asserted continuously is accepted again on the first IDLE cycle after DONE. Each operation therefore occupies NIBBLES+2 cycles including the IDLE cycle.
- Wrap-around: the result is modulo 2^WIDTH, and the excess is reported on carry.
- idx width is clog2(NIBBLES), minimum 1 bit. idx never exceeds NIBBLES-1.
- Exactly one full_adder4 instance; no other adder logic in the datapath.

Test Plan:
- Reset, then hold idle for 3 cycles -> ready=1, busy=0, done=0, sum=0x0000, carry=0, overflow=0.
- WIDTH=16, a=0x1234, b=0x4321, c_in=0, sub=0, start pulsed at edge k -> busy for cycles k+1..k+4; done pulses in cycle k+5; sum=0x5555, carry=0, overflow=0.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, carry=1, overflow=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, carry=0, overflow=1.
- sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, carry=0 (borrow). Then a=0x0007, b=0x0005 -> sum=0x0002, carry=1.
- During busy, pulse start with a=0x1111, b=0x1111 -> ignored; the first result still completes with its own values. Hold start high with fixed operands -> done pulses every 6 cycles.
- Assert reset in the 2nd ADD cycle -> no done pulse; sum=0, ready=1 next cycle; a following 0x0001+0x0001 operation yields 0x0002.
